// File: rtl/hit_indicator_pkg.sv
// Shared definitions for the hit indicator lanes: the lane-state encoding,
// default timing constants and a counter-width helper.
package hit_indicator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } lane_state_t;

    localparam int DEFAULT_LANES      = 4;
    localparam int DEFAULT_ON_CYCLES  = 3;
    localparam int DEFAULT_GAP_CYCLES = 2;

    // The down-counter must hold the larger of the two phase lengths.
    function automatic int counterWidth(input int onCycles, input int gapCycles);
        int maxCycles;
        maxCycles = (onCycles > gapCycles) ? onCycles : gapCycles;
        return (maxCycles < 1) ? 1 : $clog2(maxCycles + 1);
    endfunction

endpackage

// File: rtl/hit_indicator_if.sv
// Event/indicator bundle between the game logic (master) and the indicator
// driver (slave): hit pulses in, registered led/busy/drop levels out.
interface hit_indicator_if
    import hit_indicator_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES
);
    logic [LANES-1:0] hit;
    logic [LANES-1:0] led;
    logic [LANES-1:0] busy;
    logic [LANES-1:0] drop;

    modport master (output hit, input led, input busy, input drop);
    modport slave  (input hit, output led, output busy, output drop);
endinterface

// File: rtl/hit_indicator_lane.sv
// One indicator lane: stretches a hit pulse into an ON period followed by a
// mandatory GAP, with a single pending slot for a hit that arrives while busy.
module hit_lane
    import hit_indicator_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hit,
    output logic o_led,
    output logic o_busy,
    output logic o_drop
);

    localparam int CW = counterWidth(ON_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    lane_state_t   r_state;
    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          r_led;
    logic          r_busy;
    logic          r_drop;

    // Lane FSM; led/busy are decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_hit) begin
                        r_state <= ON;
                        r_count <= ON_LOAD;
                        r_led   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ON: begin
                    if (r_count == '0) begin
                        r_state <= GAP;
                        r_count <= GAP_LOAD;
                        r_led   <= 1'b0;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                    if (i_hit) begin
                        if (r_pending) r_drop    <= 1'b1;
                        else           r_pending <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_count == '0) begin
                        if (r_pending || i_hit) begin
                            r_state   <= ON;
                            r_count   <= ON_LOAD;
                            r_led     <= 1'b1;
                            r_pending <= r_pending & i_hit;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count - CW'(1);
                        if (i_hit) begin
                            if (r_pending) r_drop    <= 1'b1;
                            else           r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_count   <= '0;
                    r_pending <= 1'b0;
                    r_led     <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;
    assign o_drop = r_drop;

endmodule

// File: rtl/hit_indicator.sv
// Multi-lane indicator driver: one independent hit_lane per bit of the bus.
module hit_indicator
    import hit_indicator_pkg::*;
#(
    parameter int LANES      = DEFAULT_LANES,
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    hit_indicator_if.slave  bus
);

    logic [LANES-1:0] w_led;
    logic [LANES-1:0] w_busy;
    logic [LANES-1:0] w_drop;

    // Lanes share nothing but clock and reset; no arbitration between them.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hit_lane #(
            .ON_CYCLES  (ON_CYCLES),
            .GAP_CYCLES (GAP_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_hit  (bus.hit[g]),
            .o_led  (w_led[g]),
            .o_busy (w_busy[g]),
            .o_drop (w_drop[g])
        );
    end

    assign bus.led  = w_led;
    assign bus.busy = w_busy;
    assign bus.drop = w_drop;

endmodule

// File: tb/tb_hit_indicator.sv
// Directed bench for hit_indicator: a timeline model of each lane (period start
// cycle, pending flag, drop cycle) is compared against the DUT every cycle,
// plus literal expectations at key points of each scenario.
module tb_hit_indicator;
    import hit_indicator_pkg::*;

    localparam int LANES  = 4;
    localparam int ONC    = 3;
    localparam int GAPC   = 2;
    localparam int PERIOD = ONC + GAPC;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hit_indicator_if #(.LANES(LANES)) bus ();

    hit_indicator #(
        .LANES      (LANES),
        .ON_CYCLES  (ONC),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passCount  = 0;
    int checkCount = 0;
    int edgeNum    = 0;
    bit checkEn    = 1'b0;

    int startCyc [LANES];
    bit pend     [LANES];
    int dropCyc  [LANES];

    // Timeline model: a period starting at cycle s covers s..s+PERIOD-1 with led in s..s+ONC-1.
    task automatic modelUpdate(input logic [LANES-1:0] h, input logic r);
        int  e;
        bit  active;
        e = edgeNum;
        for (int i = 0; i < LANES; i++) begin
            if (r) begin
                startCyc[i] = -1000;
                pend[i]     = 1'b0;
                dropCyc[i]  = -1;
            end else begin
                active = (e >= startCyc[i]) && (e <= startCyc[i] + PERIOD - 1);
                if (!active) begin
                    if (h[i]) startCyc[i] = e + 1;
                end else if (e == startCyc[i] + PERIOD - 1) begin
                    if (pend[i] || h[i]) begin
                        startCyc[i] = e + 1;
                        pend[i]     = pend[i] && h[i];
                    end
                end else if (h[i]) begin
                    if (pend[i]) dropCyc[i] = e + 1;
                    else         pend[i]    = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [LANES-1:0] expLed(input int c);
        logic [LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i] = (c >= startCyc[i]) && (c < startCyc[i] + ONC);
        return v;
    endfunction

    function automatic logic [LANES-1:0] expBusy(input int c);
        logic [LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i] = (c >= startCyc[i]) && (c < startCyc[i] + PERIOD);
        return v;
    endfunction

    function automatic logic [LANES-1:0] expDrop(input int c);
        logic [LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i] = (dropCyc[i] == c);
        return v;
    endfunction

    task automatic compareVec(input string name, input logic [LANES-1:0] act, input logic [LANES-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, edgeNum, act, exp);
    endtask

    // Drive one edge's inputs on the falling edge, then advance the model at the rising edge.
    task automatic applyStimulus(input logic [LANES-1:0] h, input logic r);
        @(negedge clk);
        bus.hit = h;
        rst     = r;
        @(posedge clk);
        modelUpdate(h, r);
        edgeNum++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, 1'b0);
    endtask

    // Literal expectations: checked against both the DUT and the model.
    task automatic checkOutput(input string name, input logic [LANES-1:0] eLed,
                               input logic [LANES-1:0] eBusy, input logic [LANES-1:0] eDrop);
        compareVec({name, " led"},  bus.led,  eLed);
        compareVec({name, " busy"}, bus.busy, eBusy);
        compareVec({name, " drop"}, bus.drop, eDrop);
        compareVec({name, " model led"},  expLed(edgeNum),  eLed);
        compareVec({name, " model busy"}, expBusy(edgeNum), eBusy);
        compareVec({name, " model drop"}, expDrop(edgeNum), eDrop);
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            compareVec("cycle led",  bus.led,  expLed(edgeNum));
            compareVec("cycle busy", bus.busy, expBusy(edgeNum));
            compareVec("cycle drop", bus.drop, expDrop(edgeNum));
        end
    end

    initial begin
        for (int i = 0; i < LANES; i++) begin
            startCyc[i] = -1000;
            pend[i]     = 1'b0;
            dropCyc[i]  = -1;
        end
        rst     = 1'b1;
        bus.hit = '0;

        applyStimulus('0, 1'b1);
        checkEn = 1'b1;
        checkOutput("reset", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus('0, 1'b1);
        idle(2);

        // Single hit on lane 0
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s1 c1", 4'b0001, 4'b0001, 4'b0000);
        idle(2);
        checkOutput("s1 c3", 4'b0001, 4'b0001, 4'b0000);
        idle(1);
        checkOutput("s1 c4", 4'b0000, 4'b0001, 4'b0000);
        idle(1);
        checkOutput("s1 c5", 4'b0000, 4'b0001, 4'b0000);
        idle(1);
        checkOutput("s1 c6", 4'b0000, 4'b0000, 4'b0000);
        idle(2);

        // Lane 1: second hit during ON is held pending
        applyStimulus(4'b0010, 1'b0);
        idle(1);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("s2 c3", 4'b0010, 4'b0010, 4'b0000);
        idle(2);
        checkOutput("s2 c5", 4'b0000, 4'b0010, 4'b0000);
        idle(1);
        checkOutput("s2 c6", 4'b0010, 4'b0010, 4'b0000);
        idle(4);
        checkOutput("s2 c10", 4'b0000, 4'b0010, 4'b0000);
        idle(1);
        checkOutput("s2 c11", 4'b0000, 4'b0000, 4'b0000);
        idle(2);

        // Lane 2: third hit overflows the pending slot
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("s3 c3", 4'b0100, 4'b0100, 4'b0100);
        idle(1);
        checkOutput("s3 c4", 4'b0000, 4'b0100, 4'b0000);
        idle(2);
        checkOutput("s3 c6", 4'b0100, 4'b0100, 4'b0000);
        idle(5);
        checkOutput("s3 c11", 4'b0000, 4'b0000, 4'b0000);
        idle(2);

        // Lane 3: hit in the final GAP cycle restarts with no idle cycle
        applyStimulus(4'b1000, 1'b0);
        idle(4);
        checkOutput("s4 c5", 4'b0000, 4'b1000, 4'b0000);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("s4 c6", 4'b1000, 4'b1000, 4'b0000);
        idle(6);

        // All lanes, reset mid-period with a simultaneous hit
        applyStimulus(4'b1111, 1'b0);
        idle(1);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("s5 c3", 4'b0000, 4'b0000, 4'b0000);
        idle(1);
        checkOutput("s5 c4", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s5 c5", 4'b0001, 4'b0001, 4'b0000);
        idle(2);
        checkOutput("s5 c7", 4'b0001, 4'b0001, 4'b0000);
        idle(1);
        checkOutput("s5 c8", 4'b0000, 4'b0001, 4'b0000);
        idle(3);

        // Lanes 0 and 3 together, lane 0 re-hit
        applyStimulus(4'b1001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s6 c2", 4'b1001, 4'b1001, 4'b0000);
        idle(3);
        checkOutput("s6 c5", 4'b0000, 4'b1001, 4'b0000);
        idle(1);
        checkOutput("s6 c6", 4'b0001, 4'b0001, 4'b0000);
        idle(6);

        // Lane 1 held high: one hit per cycle, repeated drops
        for (int k = 0; k < 6; k++) applyStimulus(4'b0010, 1'b0);
        idle(12);

        checkEn = 1'b0;
        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
